// File: rtl/wb_mem_responder.sv
// wb_mem_responder: Wishbone-classic on-chip word memory standing in for the DRAM wrapper; `WB_RESP_RANDOM_STALL_EN` adds 0-3 LFSR-driven stall cycles.
// Latency ACK_LATENCY cycles from accept to ack_o; one request in flight, no backpressure beyond the ack wait, cyc_i drop in WAIT aborts.
module wb_mem_responder #(
  parameter int WORD_SIZE   = 256,
  parameter int ADDR_WIDTH  = 25,
  parameter int DEPTH_LOG2  = 6,
  parameter int INIT_CYCLES = 16,
  parameter int ACK_LATENCY = 4
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  output logic                 initialized,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 ack_o
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int INIT_W = $clog2(INIT_CYCLES) + 1;
  localparam int LAT_W  = $clog2(ACK_LATENCY + 4) + 1;

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
  localparam logic [LAT_W-1:0]  LAT_BASE  = LAT_W'(ACK_LATENCY - 1);
  localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [INIT_W-1:0]      init_cnt;
  logic [INIT_W-1:0]      init_cnt_nxt;
  logic [LAT_W-1:0]       lat_cnt;
  logic [LAT_W-1:0]       lat_cnt_nxt;
  logic [LAT_W-1:0]       wait_total;
  logic [1:0]             extra_wait;
  logic                   accept;
  logic                   enter_ack;

  logic                   req_we;
  logic [DEPTH_LOG2-1:0]  req_idx;
  logic [WORD_SIZE-1:0]   req_dat;

  logic                   acc_we;
  logic [DEPTH_LOG2-1:0]  acc_idx;
  logic [WORD_SIZE-1:0]   acc_dat;

  logic [ADDR_WIDTH-1:0]  word_idx;
  logic [DEPTH_LOG2-1:0]  bus_idx;
  logic                   unused_addr_bits;

  logic [WORD_SIZE-1:0]   mem [DEPTH];

  // Out-of-range word indexes alias onto the low DEPTH_LOG2 bits.
  assign word_idx         = addr_i[31 -: ADDR_WIDTH];
  assign bus_idx          = word_idx[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^{word_idx[ADDR_WIDTH-1:DEPTH_LOG2], addr_i[31-ADDR_WIDTH:0]};

`ifdef WB_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  assign extra_wait = lfsr[1:0];
`else
  assign extra_wait = 2'd0;
`endif

  // Number of WAIT cycles this request spends before ACK.
  assign wait_total = LAT_BASE + LAT_W'(extra_wait);

  // With ACK_LATENCY=1 the access happens on the accepting edge, so bypass the latches.
  assign acc_we  = (state == S_IDLE) ? we_i    : req_we;
  assign acc_idx = (state == S_IDLE) ? bus_idx : req_idx;
  assign acc_dat = (state == S_IDLE) ? data_i  : req_dat;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    lat_cnt_nxt  = lat_cnt;
    accept       = 1'b0;
    enter_ack    = 1'b0;
    case (state)
      S_INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          init_cnt_nxt = init_cnt + INIT_ONE;
        end
      end
      S_IDLE: begin
        if (cyc_i && stb_i) begin
          accept = 1'b1;
          if (wait_total == '0) begin
            state_nxt = S_ACK;
            enter_ack = 1'b1;
          end else begin
            state_nxt   = S_WAIT;
            lat_cnt_nxt = wait_total - LAT_ONE;
          end
        end
      end
      S_WAIT: begin
        // Initiator withdrawal wins over a same-cycle expiry.
        if (!cyc_i) begin
          state_nxt = S_IDLE;
        end else if (lat_cnt == '0) begin
          state_nxt = S_ACK;
          enter_ack = 1'b1;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_ONE;
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      init_cnt    <= '0;
      lat_cnt     <= '0;
      initialized <= 1'b0;
      ack_o       <= 1'b0;
      data_o      <= '0;
      req_we      <= 1'b0;
      req_idx     <= '0;
      req_dat     <= '0;
    end else begin
      init_cnt <= init_cnt_nxt;
      lat_cnt  <= lat_cnt_nxt;
      ack_o    <= enter_ack;
      if (state == S_INIT && state_nxt == S_IDLE) begin
        initialized <= 1'b1;
      end
      if (accept) begin
        req_we  <= we_i;
        req_idx <= bus_idx;
        req_dat <= data_i;
      end
      if (enter_ack && !acc_we) begin
        data_o <= mem[acc_idx];
      end
    end
  end

  // Memory contents survive reset; the rst term keeps a reset racing a clock edge from writing.
  always_ff @(posedge sys_clk) begin
    if (enter_ack && acc_we && !rst) begin
      mem[acc_idx] <= acc_dat;
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench for wb_mem_responder: vector table, abort/reset sequences and random traffic vs a memory model.
module tb_wb_mem_responder;

  localparam int WS       = 256;
  localparam int AW       = 25;
  localparam int DL       = 6;
  localparam int INIT_CYC = 16;
  localparam int LAT      = 4;

  logic          sys_clk = 1'b0;
  logic          rst     = 1'b1;
  logic          initialized;
  logic          cyc_i   = 1'b0;
  logic          stb_i   = 1'b0;
  logic          we_i    = 1'b0;
  logic [31:0]   addr_i  = '0;
  logic [WS-1:0] data_i  = '0;
  logic [WS-1:0] data_o;
  logic          ack_o;

  wb_mem_responder #(
    .WORD_SIZE  (WS),
    .ADDR_WIDTH (AW),
    .DEPTH_LOG2 (DL),
    .INIT_CYCLES(INIT_CYC),
    .ACK_LATENCY(LAT)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .initialized(initialized),
    .cyc_i      (cyc_i),
    .stb_i      (stb_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ack_o      (ack_o)
  );

  always #5 sys_clk = ~sys_clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [WS-1:0] mem_m [1 << DL];
  bit            mem_v [1 << DL];
  logic [WS-1:0] last_rd = '0;
  bit            last_known = 1'b1;
  logic [15:0]   lfsr_m = 16'hACE1;

  typedef struct {
    bit            we;
    logic [31:0]   addr;
    logic [WS-1:0] wdat;
    logic [WS-1:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [WS-1:0] got, input logic [WS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> (32 - AW)) % (1 << DL));
  endfunction

  // Expected latency of the next accepted request; the stall source steps once per accept.
  task automatic accept_model(output int lat);
    lat = LAT;
`ifdef WB_RESP_RANDOM_STALL_EN
    lat = lat + int'(lfsr_m[1:0]);
    lfsr_m = {^(lfsr_m & 16'h002D), lfsr_m[15:1]};
`endif
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ack_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_init(output int n, output bit early_ack);
    n = 0;
    early_ack = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (ack_o) early_ack = 1'b1;
      if (initialized) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic xfer(input bit we, input logic [31:0] addr, input logic [WS-1:0] wdat,
                      input bit chk_rd, input logic [WS-1:0] exp_rd, input string name);
    int lat_exp;
    int lat;
    int idx;
    idx = idx_of(addr);
    accept_model(lat_exp);
    cyc_i  = 1'b1;
    stb_i  = 1'b1;
    we_i   = we;
    addr_i = addr;
    data_i = wdat;
    wait_ack(lat);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    chk({name, " latency"}, WS'(lat), WS'(lat_exp));
    if (we) begin
      mem_m[idx] = wdat;
      mem_v[idx] = 1'b1;
      if (last_known) chk({name, " data_o held on write"}, data_o, last_rd);
    end else if (chk_rd) begin
      chk({name, " rdata"}, data_o, exp_rd);
      last_rd    = exp_rd;
      last_known = 1'b1;
    end else begin
      last_known = 1'b0;
    end
    tick();
    chk({name, " single ack"}, WS'(ack_o), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [WS-1:0] d_a;
    logic [WS-1:0] d_b;
    logic [WS-1:0] p5;
    logic [WS-1:0] rd;
    int            n;
    int            dummy;
    bit            early;
    bit            seen;

    d_a = {2{128'hAABB_CCDD_EEFF_0011_2233_4455_6677_8899}};
    d_b = {32{8'h3C}};
    p5  = {16{16'hC0DE}};

    tbl[0] = '{1'b1, 32'h0000_0000, d_a,             '0};
    tbl[1] = '{1'b0, 32'h0000_0000, '0,              d_a};
    tbl[2] = '{1'b1, 32'h0000_0180, {32{8'hA5}},     '0};
    tbl[3] = '{1'b1, 32'h0000_2180, {32{8'h5A}},     '0};
    tbl[4] = '{1'b0, 32'h0000_0180, '0,              {32{8'h5A}}};
    tbl[5] = '{1'b1, 32'h0000_0280, p5,              '0};
    tbl[6] = '{1'b0, 32'h0000_0280, '0,              p5};
    tbl[7] = '{1'b0, 32'hFFF0_2180, '0,              {32{8'h5A}}};

    // Reset with a request already pending on the bus.
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = 1'b0;
    repeat (3) tick();
    chk("reset ack_o", WS'(ack_o), '0);
    chk("reset data_o", data_o, '0);
    chk("reset initialized", WS'(initialized), '0);
    rst    = 1'b0;
    lfsr_m = 16'hACE1;
    wait_init(n, early);
    chk("init delay", WS'(n), WS'(INIT_CYC));
    chk("no ack before init", WS'(early), '0);
    accept_model(dummy);
    wait_ack(n);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    chk("first ack latency", WS'(n), WS'(dummy));
    last_known = 1'b0;
    tick();
    chk("first single ack", WS'(ack_o), '0);

    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].we, tbl[i].addr, tbl[i].wdat, !tbl[i].we, tbl[i].exp_rd, $sformatf("vec%0d", i));
    end

    // Read aborted by dropping cyc_i after two WAIT cycles.
    accept_model(dummy);
    cyc_i  = 1'b1;
    stb_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 32'h0;
    seen   = 1'b0;
    tick();
    if (ack_o) seen = 1'b1;
    tick();
    if (ack_o) seen = 1'b1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    repeat (8) begin
      tick();
      if (ack_o) seen = 1'b1;
    end
    chk("abort no ack", WS'(seen), '0);
    chk("abort data_o held", data_o, last_rd);
    xfer(1'b1, 32'h0, d_b, 1'b0, '0, "post-abort write");
    xfer(1'b0, 32'h0, '0, 1'b1, d_b, "post-abort read");

    // Reset during the WAIT of a write to word 5.
    accept_model(dummy);
    cyc_i  = 1'b1;
    stb_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = 32'h0000_0280;
    data_i = {32{8'hFF}};
    tick();
    tick();
    #2;
    rst   = 1'b1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    #1;
    chk("mid-op reset ack_o", WS'(ack_o), '0);
    chk("mid-op reset initialized", WS'(initialized), '0);
    chk("mid-op reset data_o", data_o, '0);
    lfsr_m     = 16'hACE1;
    last_rd    = '0;
    last_known = 1'b1;
    tick();
    rst = 1'b0;
    wait_init(n, early);
    chk("re-init delay", WS'(n), WS'(INIT_CYC));
    xfer(1'b0, 32'h0000_0280, '0, 1'b1, p5, "word5 after reset");

    // Random traffic against the memory model, reads only to known words.
    for (int i = 0; i < 30; i++) begin
      bit            we;
      logic [31:0]   addr;
      logic [WS-1:0] wd;
      int            idx;
      we   = ($urandom_range(0, 1) == 1);
      addr = $urandom;
      idx  = idx_of(addr);
      if (!we && !mem_v[idx]) we = 1'b1;
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rd = mem_m[idx];
      xfer(we, addr, wd, !we, rd, $sformatf("rand%0d", i));
    end
    chk("initialized stays high", WS'(initialized), WS'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mem_responder.md
# wb_mem_responder

Wishbone-classic responder that stands in for the DRAM wrapper behind a bus initiator. It presents the same request/acknowledge port shape and the same `initialized` flag as the wrapper. Internally it uses a small on-chip word memory with a programmable init delay and ack latency. It lets test-harness initiators and firmware be brought up in simulation and on FPGA without the DDR3 PHY.

## Interface
- `WORD_SIZE`, 256: data word width in bits.
- `ADDR_WIDTH`, 25: word-index width; word index = `addr_i[31 -: ADDR_WIDTH]`.
- `DEPTH_LOG2`, 6: memory holds 2^DEPTH_LOG2 words; index = low DEPTH_LOG2 bits of word index.
- `INIT_CYCLES`, 16: cycles after reset before `initialized` rises (≥1).
- `ACK_LATENCY`, 4: cycles from request acceptance to `ack_o` (≥1).

Ports:
- `sys_clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `initialized` out 1: high once the init delay has expired.
- `cyc_i` in 1: bus cycle valid.
- `stb_i` in 1: strobe.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: byte address; the low 32−ADDR_WIDTH bits are ignored.
- `data_i` in WORD_SIZE: write data.
- `data_o` out WORD_SIZE: read data, registered.
- `ack_o` out 1: one-cycle acknowledge, registered.

## Operation
- States: INIT, IDLE, WAIT, ACK.
- INIT:
  - Counter runs 0..INIT_CYCLES−1 with `initialized`=0; requests are ignored (no ack).
  - On the terminal count, go to IDLE and set `initialized`=1. It stays 1 until reset.
- IDLE:
  - When `cyc_i & stb_i` is sampled high, latch `we_i`, the memory index, and `data_i`, then load the latency counter.
  - Go to ACK if ACK_LATENCY=1, else WAIT.
- WAIT:
  - Decrement the counter; go to ACK when it expires.
  - If `cyc_i` is sampled low in WAIT, the request aborts: return to IDLE, no ack, no memory write.
- ACK:
  - `ack_o`=1 for exactly one cycle.
  - On entry, a write stores the latched data at the latched index; a read loads `data_o` from the latched index.
  - Next state is IDLE unconditionally. Back-to-back requests are therefore accepted no earlier than the cycle after ACK.
- `data_o` is updated only on read acks. It holds its value through writes, idle, and aborts.
- Out-of-range word indexes alias modulo 2^DEPTH_LOG2; there is no error response.
- Memory contents are not cleared by reset. After power-up they are undefined (0 in simulation).
- Reset mid-operation: the pending access is dropped with no write. All outputs return to reset values and INIT restarts.

## Timing
- Reset values: `ack_o`=0, `data_o`=0, `initialized`=0, state=INIT.
- `initialized` rises in the cycle following the INIT_CYCLES-th rising edge after reset release.
- Request sampled at edge E → `ack_o` is high in the cycle after edge E+ACK_LATENCY−1, i.e. ACK_LATENCY cycles of latency.
- Read data is valid in the same cycle as `ack_o` and is held afterwards.
- The initiator drops `stb_i` on the edge that samples `ack_o`. The responder is back in IDLE at that edge, so no second ack occurs.
- The write takes effect at the edge entering ACK. A read accepted in the cycle after a write's ACK returns the new data.

## Configuration
- `WB_RESP_RANDOM_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reset to the seed) advances on every accepted request.
  - Its low 2 bits add 0–3 extra WAIT cycles to that request.
  - Sequence is deterministic after reset.
- Undefined: latency is exactly ACK_LATENCY and no LFSR is instantiated.

## Test plan
- Reset release, `cyc_i`/`stb_i` held high from cycle 0 → no `ack_o` before `initialized`. `initialized` rises after 16 cycles; the first ack arrives 4 cycles after the first IDLE sample.
- Write 256'hAABB_CCDD_EEFF_0011_2233_4455_6677_8899 (repeated ×2) to addr 32'h0000_0000, then read the same address → ack 4 cycles after each accept; `data_o` equals the written word.
- Write 32{8'hA5} at word 3 (addr 32'h180) and 32{8'h5A} at word 67 (addr 32'h2180), then read word 3 → returns 32{8'h5A} (aliasing at DEPTH_LOG2=6).
- Read request with `cyc_i` dropped after 2 WAIT cycles → no ack and `data_o` unchanged. A subsequent write then read at the same address returns the new value.
- Assert `rst` during WAIT of a write of 32{8'hFF} to word 5 → `ack_o`=0 and `initialized`=0 immediately. After re-init, a read of word 5 returns its prior contents, not 32{8'hFF}.
- With `WB_RESP_RANDOM_STALL_EN`, 8 back-to-back reads → each latency lies in 4..7 and matches the LFSR model; exactly one ack per request.
